// File: rtl/fir_run_sequencer.sv
// Run sequencer for the FIR datapath: loads a coefficient set, then walks one
// sample at a time through feed, compute, wait and result hand-off.
module fir_run_sequencer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_TAPS   = 32,
   parameter int unsigned TAP_W      = 6,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cfg_clear,
   input  logic                  cfg_load_start,
   input  logic [TAP_W-1:0]      cfg_tap_count,
   input  logic                  cfg_enable,
   input  logic                  coeff_wr_valid,
   input  logic [DATA_WIDTH-1:0] coeff_wr_data,
   input  logic                  s_sample_valid,
   output logic                  s_sample_ready,
   input  logic [DATA_WIDTH-1:0] s_sample_data,
   output logic                  m_result_valid,
   input  logic                  m_result_ready,
   output logic [DATA_WIDTH-1:0] m_result_data,
   output logic [TAP_W-1:0]      dp_tap_count,
   output logic                  dp_coeff_valid,
   output logic [DATA_WIDTH-1:0] dp_coeff_data,
   output logic                  dp_in_valid,
   output logic [DATA_WIDTH-1:0] dp_in_data,
   output logic                  dp_compute,
   input  logic                  dp_out_valid,
   input  logic [DATA_WIDTH-1:0] dp_out_data,
   input  logic                  dp_error,
   output logic                  busy,
   output logic                  coeff_loaded,
   output logic [1:0]            err_code,
   output logic [2:0]            state_o,
   output logic [31:0]           sample_count
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TAP_W-1:0] MAX_TAPS_W = TAP_W'(MAX_TAPS);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TAPS    = 2'd1;
   localparam logic [1:0] ERR_DP      = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_READY   = 3'd2,
      ST_FEED    = 3'd3,
      ST_COMPUTE = 3'd4,
      ST_WAIT    = 3'd5,
      ST_OUT     = 3'd6,
      ST_ERROR   = 3'd7
   } state_t;

   state_t                state, state_n;
   logic [TAP_W-1:0]      coeff_cnt, coeff_cnt_n;
   logic [TO_W-1:0]       to_cnt, to_cnt_n;
   logic [TAP_W-1:0]      tap_n;
   logic                  coeff_valid_n;
   logic [DATA_WIDTH-1:0] coeff_data_n;
   logic [DATA_WIDTH-1:0] in_data_n;
   logic [DATA_WIDTH-1:0] result_data_n;
   logic                  loaded_n;
   logic [1:0]            err_n;
   logic [31:0]           count_n;
   logic                  dp_err_live;
   logic                  load_live;
   logic                  taps_bad;
   logic [TAP_W-1:0]      coeff_cnt_inc;

   assign s_sample_ready = (state == ST_READY) & cfg_enable & ~cfg_load_start & ~cfg_clear;
   assign state_o        = state;

   assign dp_err_live   = dp_error & ((state == ST_FEED) | (state == ST_COMPUTE) |
                                      (state == ST_WAIT) | (state == ST_OUT));
   assign load_live     = cfg_load_start & ((state == ST_IDLE) | (state == ST_READY) |
                                            (state == ST_ERROR));
   assign taps_bad      = (cfg_tap_count == '0) | (cfg_tap_count > MAX_TAPS_W);
   assign coeff_cnt_inc = coeff_cnt + TAP_W'(1);

   // Next-state and next register values; priority clear > dp_error > load > flow
   always_comb begin
      state_n       = state;
      coeff_cnt_n   = coeff_cnt;
      to_cnt_n      = to_cnt;
      tap_n         = dp_tap_count;
      coeff_valid_n = 1'b0;
      coeff_data_n  = dp_coeff_data;
      in_data_n     = dp_in_data;
      result_data_n = m_result_data;
      loaded_n      = coeff_loaded;
      err_n         = err_code;
      count_n       = sample_count;

      if (cfg_clear) begin
         state_n     = ST_IDLE;
         loaded_n    = 1'b0;
         err_n       = ERR_NONE;
         count_n     = '0;
         coeff_cnt_n = '0;
      end else if (dp_err_live) begin
         state_n  = ST_ERROR;
         err_n    = ERR_DP;
         loaded_n = 1'b0;
      end else if (load_live) begin
         loaded_n = 1'b0;
         if (taps_bad) begin
            state_n = ST_ERROR;
            err_n   = ERR_TAPS;
         end else begin
            state_n     = ST_LOAD;
            tap_n       = cfg_tap_count;
            coeff_cnt_n = '0;
            err_n       = ERR_NONE;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (coeff_wr_valid) begin
                  coeff_valid_n = 1'b1;
                  coeff_data_n  = coeff_wr_data;
                  coeff_cnt_n   = coeff_cnt_inc;
                  if (coeff_cnt_inc == dp_tap_count) begin
                     state_n  = ST_READY;
                     loaded_n = 1'b1;
                  end
               end
            end
            ST_READY: begin
               if (s_sample_ready && s_sample_valid) begin
                  in_data_n = s_sample_data;
                  state_n   = ST_FEED;
               end
            end
            ST_FEED: state_n = ST_COMPUTE;
            ST_COMPUTE: begin
               to_cnt_n = '0;
               state_n  = ST_WAIT;
            end
            ST_WAIT: begin
               if (dp_out_valid) begin
                  result_data_n = dp_out_data;
                  state_n       = ST_OUT;
               end else if (to_cnt == TO_LAST) begin
                  state_n  = ST_ERROR;
                  err_n    = ERR_TIMEOUT;
                  loaded_n = 1'b0;
               end else begin
                  to_cnt_n = to_cnt + TO_W'(1);
               end
            end
            ST_OUT: begin
               if (m_result_ready) begin
                  count_n = sample_count + 32'd1;
                  state_n = ST_READY;
               end
            end
            default: ;
         endcase
      end
   end

   // State and registered outputs; strobes follow the state being entered
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= ST_IDLE;
         coeff_cnt      <= '0;
         to_cnt         <= '0;
         dp_tap_count   <= '0;
         dp_coeff_valid <= 1'b0;
         dp_coeff_data  <= '0;
         dp_in_valid    <= 1'b0;
         dp_in_data     <= '0;
         dp_compute     <= 1'b0;
         m_result_valid <= 1'b0;
         m_result_data  <= '0;
         busy           <= 1'b0;
         coeff_loaded   <= 1'b0;
         err_code       <= ERR_NONE;
         sample_count   <= '0;
      end else begin
         state          <= state_n;
         coeff_cnt      <= coeff_cnt_n;
         to_cnt         <= to_cnt_n;
         dp_tap_count   <= tap_n;
         dp_coeff_valid <= coeff_valid_n;
         dp_coeff_data  <= coeff_data_n;
         dp_in_valid    <= (state_n == ST_FEED);
         dp_in_data     <= in_data_n;
         dp_compute     <= (state_n == ST_COMPUTE);
         m_result_valid <= (state_n == ST_OUT);
         m_result_data  <= result_data_n;
         busy           <= (state_n != ST_IDLE) & (state_n != ST_READY) & (state_n != ST_ERROR);
         coeff_loaded   <= loaded_n;
         err_code       <= err_n;
         sample_count   <= count_n;
      end
   end

endmodule

// File: tb/tb_fir_run_sequencer.sv
// Self-checking bench for fir_run_sequencer: table-driven sample round trips
// with a result scoreboard, plus hand sequences for load, errors and reset.
`timescale 1ns/1ps
module tb_fir_run_sequencer;
   localparam int unsigned DW      = 32;
   localparam int unsigned TAP_W   = 6;
   localparam int unsigned TIMEOUT = 64;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cfg_clear, cfg_load_start, cfg_enable;
   logic [TAP_W-1:0] cfg_tap_count;
   logic          coeff_wr_valid;
   logic [DW-1:0] coeff_wr_data;
   logic          s_sample_valid, s_sample_ready;
   logic [DW-1:0] s_sample_data;
   logic          m_result_valid, m_result_ready;
   logic [DW-1:0] m_result_data;
   logic [TAP_W-1:0] dp_tap_count;
   logic          dp_coeff_valid;
   logic [DW-1:0] dp_coeff_data;
   logic          dp_in_valid;
   logic [DW-1:0] dp_in_data;
   logic          dp_compute;
   logic          dp_out_valid;
   logic [DW-1:0] dp_out_data;
   logic          dp_error;
   logic          busy, coeff_loaded;
   logic [1:0]    err_code;
   logic [2:0]    state_o;
   logic [31:0]   sample_count;

   always #5 clk = ~clk;

   fir_run_sequencer #(.DATA_WIDTH(DW), .MAX_TAPS(32), .TAP_W(TAP_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn), .cfg_clear(cfg_clear), .cfg_load_start(cfg_load_start),
      .cfg_tap_count(cfg_tap_count), .cfg_enable(cfg_enable),
      .coeff_wr_valid(coeff_wr_valid), .coeff_wr_data(coeff_wr_data),
      .s_sample_valid(s_sample_valid), .s_sample_ready(s_sample_ready), .s_sample_data(s_sample_data),
      .m_result_valid(m_result_valid), .m_result_ready(m_result_ready), .m_result_data(m_result_data),
      .dp_tap_count(dp_tap_count), .dp_coeff_valid(dp_coeff_valid), .dp_coeff_data(dp_coeff_data),
      .dp_in_valid(dp_in_valid), .dp_in_data(dp_in_data), .dp_compute(dp_compute),
      .dp_out_valid(dp_out_valid), .dp_out_data(dp_out_data), .dp_error(dp_error),
      .busy(busy), .coeff_loaded(coeff_loaded), .err_code(err_code), .state_o(state_o),
      .sample_count(sample_count)
   );

   typedef struct {
      logic [31:0] smp;
      logic [31:0] ret;
      int          lat;
      int          stall;
   } vec_t;

   vec_t        vecs[4];
   logic [31:0] sb_q[$];
   logic [31:0] exp_count;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_state"}, 32'(state_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_loaded"}, 32'(coeff_loaded), 32'd0);
      chk({tag, "_err"}, 32'(err_code), 32'd0);
      chk({tag, "_count"}, sample_count, 32'd0);
      chk({tag, "_strobes"}, 32'({dp_coeff_valid, dp_in_valid, dp_compute, m_result_valid, s_sample_ready}), 32'd0);
      chk({tag, "_taps"}, 32'(dp_tap_count), 32'd0);
      chk({tag, "_data"}, m_result_data | dp_in_data | dp_coeff_data, 32'd0);
   endtask

   task automatic write_coeffs(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         coeff_wr_valid = 1'b1;
         coeff_wr_data  = base + 32'(i);
         step();
      end
      coeff_wr_valid = 1'b0;
      chk("loaded_state", 32'(state_o), 32'd2);
      chk("coeff_loaded", 32'(coeff_loaded), 32'd1);
      chk("tap_count", 32'(dp_tap_count), 32'(n));
   endtask

   task automatic load_coeffs(input int n, input logic [31:0] base);
      cfg_load_start = 1'b1;
      cfg_tap_count  = TAP_W'(n);
      step();
      cfg_load_start = 1'b0;
      chk("load_state", 32'(state_o), 32'd1);
      write_coeffs(n, base);
   endtask

   // Handshake a sample at T and follow it to the first WAIT cycle (T+3)
   task automatic start_sample(input logic [31:0] smp, input logic [31:0] ret);
      s_sample_valid = 1'b1;
      s_sample_data  = smp;
      #1;
      chk("sample_ready", 32'(s_sample_ready), 32'd1);
      sb_q.push_back(ret);
      step();
      s_sample_valid = 1'b0;
      s_sample_data  = '0;
      chk("feed_state", 32'(state_o), 32'd3);
      chk("dp_in_valid", 32'(dp_in_valid), 32'd1);
      chk("dp_in_data", dp_in_data, smp);
      step();
      chk("compute_state", 32'(state_o), 32'd4);
      chk("dp_compute", 32'(dp_compute), 32'd1);
      chk("in_valid_once", 32'(dp_in_valid), 32'd0);
      step();
      chk("wait_state", 32'(state_o), 32'd5);
      chk("compute_once", 32'(dp_compute), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] exp;
      m_result_ready = 1'b0;
      start_sample(v.smp, v.ret);
      repeat (v.lat - 1) step();
      dp_out_valid = 1'b1;
      dp_out_data  = v.ret;
      step();
      dp_out_valid = 1'b0;
      dp_out_data  = '0;
      chk("result_valid_rise", 32'(m_result_valid), 32'd1);
      for (int s = 0; s < v.stall; s++) begin
         chk("result_held_valid", 32'(m_result_valid), 32'd1);
         if (sb_q.size() > 0) chk("result_held_data", m_result_data, sb_q[0]);
         step();
      end
      m_result_ready = 1'b1;
      chk("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         chk("result_data", m_result_data, exp);
      end
      step();
      m_result_ready = 1'b0;
      exp_count = exp_count + 32'd1;
      chk("sample_count", sample_count, exp_count);
      chk("back_ready", 32'(state_o), 32'd2);
      chk("result_valid_drop", 32'(m_result_valid), 32'd0);
   endtask

   initial begin
      logic seen;
      vecs[0] = '{smp: 32'h0000_0010, ret: 32'h0000_0ABC, lat: 3,  stall: 2};
      vecs[1] = '{smp: 32'hFFFF_FFFF, ret: 32'h1234_5678, lat: 1,  stall: 0};
      vecs[2] = '{smp: 32'h0000_0000, ret: 32'hDEAD_BEEF, lat: 64, stall: 0};
      vecs[3] = '{smp: 32'h8000_0001, ret: 32'h0000_0000, lat: 2,  stall: 1};

      rstn = 1'b0;
      cfg_clear = 1'b0; cfg_load_start = 1'b0; cfg_tap_count = '0; cfg_enable = 1'b0;
      coeff_wr_valid = 1'b0; coeff_wr_data = '0;
      s_sample_valid = 1'b0; s_sample_data = '0; m_result_ready = 1'b0;
      dp_out_valid = 1'b0; dp_out_data = '0; dp_error = 1'b0;
      exp_count = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rstn = 1'b1;
      step();
      chk("idle_after_reset", 32'(state_o), 32'd0);

      // Coefficient load: strobes one cycle late, fifth write ignored
      cfg_load_start = 1'b1;
      cfg_tap_count  = TAP_W'(4);
      step();
      cfg_load_start = 1'b0;
      chk("load_state", 32'(state_o), 32'd1);
      chk("load_busy", 32'(busy), 32'd1);
      chk("no_early_strobe", 32'(dp_coeff_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         coeff_wr_valid = 1'b1;
         coeff_wr_data  = 32'(i + 1);
         step();
         chk("coeff_valid", 32'(dp_coeff_valid), 32'd1);
         chk("coeff_data", dp_coeff_data, 32'(i + 1));
      end
      chk("ready_state", 32'(state_o), 32'd2);
      chk("coeff_loaded", 32'(coeff_loaded), 32'd1);
      coeff_wr_data = 32'd5;
      step();
      coeff_wr_valid = 1'b0;
      chk("extra_write_ignored", 32'(dp_coeff_valid), 32'd0);

      cfg_enable = 1'b1;
      foreach (vecs[i]) run_vec(vecs[i]);

      cfg_enable = 1'b0;
      s_sample_valid = 1'b1;
      #1;
      chk("disabled_not_ready", 32'(s_sample_ready), 32'd0);
      s_sample_valid = 1'b0;
      cfg_enable = 1'b1;

      // Load start beats a simultaneous sample offer
      cfg_load_start = 1'b1;
      cfg_tap_count  = TAP_W'(4);
      s_sample_valid = 1'b1;
      s_sample_data  = 32'h55;
      #1;
      chk("prio_ready_low", 32'(s_sample_ready), 32'd0);
      step();
      cfg_load_start = 1'b0;
      s_sample_valid = 1'b0;
      chk("prio_load_state", 32'(state_o), 32'd1);
      chk("prio_no_feed", 32'(dp_in_valid), 32'd0);
      write_coeffs(4, 32'h100);

      // Async reset in WAIT takes effect without a clock edge
      start_sample(32'h77, 32'h99);
      #2;
      rstn = 1'b0;
      #1;
      check_zero("async_reset");
      step();
      rstn = 1'b1;
      sb_q.delete();
      exp_count = '0;
      step();
      chk("idle_after_async", 32'(state_o), 32'd0);

      // Datapath error in WAIT
      load_coeffs(2, 32'h200);
      start_sample(32'h1, 32'h2);
      dp_error = 1'b1;
      step();
      dp_error = 1'b0;
      sb_q.delete();
      chk("dperr_state", 32'(state_o), 32'd7);
      chk("dperr_code", 32'(err_code), 32'd2);
      chk("dperr_loaded", 32'(coeff_loaded), 32'd0);

      // Bad tap counts: 0 from ERROR, 33 from IDLE
      cfg_load_start = 1'b1;
      cfg_tap_count  = TAP_W'(0);
      step();
      cfg_load_start = 1'b0;
      chk("tap0_state", 32'(state_o), 32'd7);
      chk("tap0_code", 32'(err_code), 32'd1);
      chk("tap0_strobes", 32'({dp_coeff_valid, dp_in_valid, dp_compute}), 32'd0);
      cfg_clear = 1'b1;
      step();
      cfg_clear = 1'b0;
      chk("clear_state", 32'(state_o), 32'd0);
      chk("clear_code", 32'(err_code), 32'd0);
      cfg_load_start = 1'b1;
      cfg_tap_count  = TAP_W'(33);
      step();
      cfg_load_start = 1'b0;
      chk("tap33_state", 32'(state_o), 32'd7);
      chk("tap33_code", 32'(err_code), 32'd1);
      chk("tap33_strobes", 32'({dp_coeff_valid, dp_in_valid, dp_compute, busy}), 32'd0);
      cfg_clear = 1'b1;
      step();
      cfg_clear = 1'b0;
      chk("clear2_code", 32'(err_code), 32'd0);

      // Largest legal tap count, then a timeout with no datapath response
      load_coeffs(32, 32'h1000);
      start_sample(32'hA, 32'hB);
      seen = 1'b0;
      repeat (TIMEOUT - 1) begin
         step();
         seen = seen | m_result_valid;
      end
      chk("timeout_still_wait", 32'(state_o), 32'd5);
      step();
      seen = seen | m_result_valid;
      sb_q.delete();
      chk("timeout_state", 32'(state_o), 32'd7);
      chk("timeout_code", 32'(err_code), 32'd3);
      chk("timeout_no_result", 32'(seen), 32'd0);

      // Clear while a result waits in OUT
      cfg_clear = 1'b1;
      step();
      cfg_clear = 1'b0;
      load_coeffs(1, 32'h7);
      m_result_ready = 1'b0;
      start_sample(32'h3, 32'h4);
      dp_out_valid = 1'b1;
      dp_out_data  = 32'h4;
      step();
      dp_out_valid = 1'b0;
      chk("out_valid", 32'(m_result_valid), 32'd1);
      cfg_clear = 1'b1;
      step();
      cfg_clear = 1'b0;
      sb_q.delete();
      chk("clear_out_valid", 32'(m_result_valid), 32'd0);
      chk("clear_out_state", 32'(state_o), 32'd0);
      chk("clear_out_loaded", 32'(coeff_loaded), 32'd0);
      chk("clear_out_count", sample_count, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_run_sequencer.md
# fir_run_sequencer

Sequencer that owns the FIR datapath's control inputs. It loads a coefficient set of programmable length, then streams samples through the datapath one at a time: feed, compute, collect result, hand off. It sits between the AXI-Lite register control unit and `FIR_datapath`. It converts register-level commands and a sample/result valid-ready stream into the datapath's strobe protocol, with error and timeout supervision.

## Interface
- `DATA_WIDTH`, 32, width of samples, coefficients, results
- `MAX_TAPS`, 32, largest legal tap count
- `TAP_W`, 6, width of tap-count fields (holds 0..MAX_TAPS)
- `TIMEOUT`, 64, max cycles in WAIT before a timeout error

Ports:
- `clk`  in  1  single clock; everything is synchronous to its rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `cfg_clear`  in  1  pulse: abort everything and return to IDLE
- `cfg_load_start`  in  1  pulse: begin coefficient load
- `cfg_tap_count`  in  TAP_W  tap count, sampled on `cfg_load_start`
- `cfg_enable`  in  1  permits sample acceptance
- `coeff_wr_valid`  in  1  one coefficient present this cycle
- `coeff_wr_data`  in  DATA_WIDTH  coefficient value
- `s_sample_valid` / `s_sample_ready` / `s_sample_data`  in/out/in  1/1/DATA_WIDTH  input sample stream
- `m_result_valid` / `m_result_ready` / `m_result_data`  out/in/out  1/1/DATA_WIDTH  result stream
- `dp_tap_count`  out  TAP_W  latched tap count to datapath
- `dp_coeff_valid` / `dp_coeff_data`  out  1/DATA_WIDTH  coefficient strobe to datapath
- `dp_in_valid` / `dp_in_data`  out  1/DATA_WIDTH  sample strobe to datapath
- `dp_compute`  out  1  one-cycle compute command
- `dp_out_valid` / `dp_out_data` / `dp_error`  in  1/DATA_WIDTH/1  datapath result and fault
- `busy`  out  1  state is not IDLE, READY or ERROR
- `coeff_loaded`  out  1  a full coefficient set is loaded
- `err_code`  out  2  sticky error cause: 0 none, 1 bad tap count, 2 datapath error, 3 timeout
- `state_o`  out  3  current state encoding, for status readback
- `sample_count`  out  32  results delivered since clear; wraps modulo 2^32

## Operation
- States (encoding): IDLE=0, LOAD=1, READY=2, FEED=3, COMPUTE=4, WAIT=5, OUT=6, ERROR=7.
- **Reset:** every output and register is 0 and the state is IDLE.
- **Priority each cycle:** `cfg_clear` > `dp_error` > `cfg_load_start` > normal flow.
- **`cfg_clear`:** from any state, go to IDLE. Clears `coeff_loaded`, `err_code`, `sample_count` and the coefficient counter. Any in-flight sample or result is discarded.
- **`cfg_load_start`:** honoured in IDLE, READY and ERROR; ignored in all other states.
  - If `cfg_tap_count` is 0 or greater than MAX_TAPS: go to ERROR with `err_code`=1.
  - Otherwise: latch the count into `dp_tap_count`, zero the coefficient counter, clear `coeff_loaded` and `err_code`, and go to LOAD.
- **LOAD:**
  - Each `coeff_wr_valid` is registered onto `dp_coeff_valid`/`dp_coeff_data` the next cycle and increments the counter.
  - When the counter reaches `dp_tap_count`, go to READY and set `coeff_loaded`=1.
  - Extra writes in that cycle or later are ignored. `coeff_wr_valid` is ignored in every state other than LOAD.
- **READY:**
  - `s_sample_ready` = READY & `cfg_enable` & ~`cfg_load_start` & ~`cfg_clear`. It is combinational.
  - On handshake, capture the sample and go to FEED.
- **FEED:** `dp_in_valid`=1 for exactly one cycle with the captured sample, then go to COMPUTE.
- **COMPUTE:** `dp_compute`=1 for exactly one cycle, then go to WAIT. The timeout counter is zeroed.
- **WAIT:**
  - On `dp_out_valid`, capture `dp_out_data` into `m_result_data` and go to OUT.
  - If `dp_out_valid` has not arrived when the counter reaches TIMEOUT, go to ERROR with `err_code`=3.
- **OUT:**
  - `m_result_valid` stays high and the data is held stable until `m_result_ready`.
  - On handshake, increment `sample_count` and go to READY.
  - `dp_out_valid` while in OUT is ignored.
- **`dp_error`:** honoured in FEED, COMPUTE, WAIT and OUT; ignored elsewhere. Go to ERROR with `err_code`=2.
- **ERROR:**
  - All dp strobes and `m_result_valid` are 0. `coeff_loaded` is cleared.
  - Exit only via `cfg_clear` or `cfg_load_start`.
- **`cfg_enable` deasserted mid-sample:** the current sample completes through OUT. No new sample is accepted.

## Timing
- **Sample path:** handshake at cycle T; `dp_in_valid` at T+1; `dp_compute` at T+2; WAIT from T+3.
- **Result path:** if `dp_out_valid` arrives at cycle W, `m_result_valid` rises at W+1. With `m_result_ready` high, the next `s_sample_ready` is possible at W+2.
- **Coefficient path:** `coeff_wr_valid` at cycle C gives `dp_coeff_valid` at C+1. READY is entered on the cycle after the last coefficient write.
- All outputs except `s_sample_ready` are registered.
- `busy` and `state_o` reflect the registered state.
- `rstn` assertion mid-operation forces reset values immediately, with no handshake completion.

## Test plan
- **Load:** `cfg_load_start` with tap count 4, four coefficient writes 1,2,3,4 on consecutive cycles. Required: `dp_coeff_valid` is high 4 cycles with data 1..4 one cycle late; `coeff_loaded`=1; state=2; a fifth write produces no strobe.
- **Sample round trip:** `cfg_enable`=1, sample 0x10 offered, datapath model returns 0xABC 3 cycles after `dp_compute`. Required: `dp_in_valid` at T+1; `dp_compute` at T+2; `m_result_data`=0xABC valid at W+1 and held across 2 stall cycles of `m_result_ready`; `sample_count`=1.
- **Bad tap count:** `cfg_load_start` with tap count 0, then with 33. Required: ERROR each time, `err_code`=1, no dp strobes. Then `cfg_clear` gives IDLE with `err_code`=0.
- **Timeout:** datapath never asserts `dp_out_valid`. Required: ERROR exactly TIMEOUT cycles after WAIT entry, `err_code`=3, `m_result_valid` stays 0.
- **Priority:** in READY, `cfg_load_start` and `s_sample_valid` in the same cycle. Required: `s_sample_ready`=0 and the next state is LOAD. `dp_error` in WAIT gives `err_code`=2. `cfg_clear` during OUT drops `m_result_valid` the next cycle.
- **Async reset:** assert `rstn`=0 mid-WAIT. Required: all outputs 0 with no clock edge, and state IDLE after release.
